// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Optional feature macro: FETCH_BYPASS_EN (used by fetch_buffer).
package fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] ins;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, ins} entries with flush.
// Flush takes priority over push/pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             wdata,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch front end: owns the PC, fetches over req/ack, buffers words for decode.
// Define FETCH_BYPASS_EN to forward an ack straight to decode when the FIFO is empty.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               ins_valid,
    input  logic               ins_ready,
    output logic [INSTR_W-1:0] ins,
    output logic [31:0]        ins_pc
);

    localparam int            CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_state_e  state, state_n;
    logic [31:0]   fetch_pc, fetch_pc_n, addr_n, pc_inc;
    logic [CW-1:0] count, count_pop, count_nxt;
    fetch_entry_t  head, wdata;
    logic          has_data, pop, take, byp, push;

    assign pc_inc   = imem_addr + PC_STEP;
    assign has_data = count != '0;
    assign pop      = has_data && ins_ready;
    assign take     = (state == WAIT) && imem_ack && !redirect;
`ifdef FETCH_BYPASS_EN
    assign byp      = take && !has_data;
`else
    assign byp      = 1'b0;
`endif
    // A bypassed word consumed this cycle never enters the FIFO.
    assign push      = take && !(byp && ins_ready);
    assign count_pop = count - CW'(pop);
    assign count_nxt = count_pop + CW'(push);
    assign wdata     = '{pc: imem_addr, ins: imem_rdata};
    assign imem_req  = state != IDLE;

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        addr_n     = imem_addr;
        if (redirect) fetch_pc_n = {redirect_pc[31:2], 2'b00};
        unique case (state)
            IDLE: begin
                if (!redirect && count_pop < FULL) begin
                    state_n = WAIT;
                    addr_n  = fetch_pc;
                end
            end
            WAIT: begin
                if (redirect) begin
                    state_n = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    fetch_pc_n = pc_inc;
                    if (count_nxt < FULL) addr_n = pc_inc;
                    else state_n = IDLE;
                end
            end
            DROP: begin
                if (imem_ack) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_addr <= RESET_PC;
        end else begin
            state     <= state_n;
            fetch_pc  <= fetch_pc_n;
            imem_addr <= addr_n;
        end
    end

    always_comb begin
        ins_valid = has_data;
        ins       = has_data ? head.ins : '0;
        ins_pc    = has_data ? head.pc  : '0;
`ifdef FETCH_BYPASS_EN
        if (byp) begin
            ins_valid = 1'b1;
            ins       = imem_rdata;
            ins_pc    = imem_addr;
        end
`endif
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios plus random traffic
// against a queue-based model of the fetch stream.
module tb_fetch_buffer;
    import fetch_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ins_valid, ins_ready = 1'b0;
    logic [31:0] ins, ins_pc;

    always #5 clk = ~clk;

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins(ins), .ins_pc(ins_pc)
    );

    int vec = 0;
    int errs = 0;

    logic [63:0] q[$];
    logic [31:0] mpc, oaddr;
    bit          out, drop;
    bit          busy;
    int          left, lat_mode;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_ins;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mpc = RPC; oaddr = RPC;
        out = 0; drop = 0;
        busy = 0; left = 0;
        imem_ack = 1'b0;
    endtask

    // Spec-level fetch model: queue of buffered words plus one
    // possibly-outstanding request that may be marked for discard.
    task automatic model_step(input bit rdy, input bit rd,
                              input logic [31:0] rpc, input bit ack);
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (rd) begin
            q.delete();
            mpc = {rpc[31:2], 2'b00};
            if (out && ack) begin
                out = 0; drop = 0;
            end else if (out) begin
                drop = 1;
            end
        end else if (out) begin
            if (ack) begin
                if (drop) begin
                    out = 0; drop = 0;
                end else begin
                    q.push_back({oaddr, memword(oaddr)});
                    mpc = oaddr + 32'd4;
                    if (q.size() < DEPTH) oaddr = mpc;
                    else out = 0;
                end
            end
        end else if (q.size() < DEPTH) begin
            out = 1; oaddr = mpc;
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cycle(input bit rdy, input bit rd, input logic [31:0] rpc);
        ins_ready = rdy; redirect = rd; redirect_pc = rpc;
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        if (imem_req) begin
            if (!busy) begin
                busy = 1;
                left = (lat_mode < 0) ? $urandom_range(0, 3) : lat_mode;
            end else if (left > 0) begin
                left--;
            end
            if (left == 0) begin
                imem_ack = 1'b1;
                imem_rdata = memword(imem_addr);
                busy = 0;
            end
        end
        #1;
        s_req = imem_req; s_addr = imem_addr; s_valid = ins_valid;
        s_pc = ins_pc; s_ins = ins;
        chk("imem_req", 32'(s_req), 32'(out));
        if (out) chk("imem_addr", s_addr, oaddr);
        chk("ins_valid", 32'(s_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("ins_pc", s_pc, q[0][63:32]);
            chk("ins", s_ins, q[0][31:0]);
        end
        @(posedge clk);
        model_step(rdy, rd, rpc, imem_ack);
        @(negedge clk);
    endtask

    // Called at a negedge: one cycle of reset, released at the next negedge.
    task automatic do_reset();
        rst_n = 1'b0; ins_ready = 1'b0; redirect = 1'b0;
        model_reset();
        #1;
        chk("rst imem_req", 32'(imem_req), 32'd0);
        chk("rst imem_addr", imem_addr, RPC);
        chk("rst ins_valid", 32'(ins_valid), 32'd0);
        chk("rst ins", ins, 32'd0);
        chk("rst ins_pc", ins_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        bit found;
        bit rdy, rd;
        logic [31:0] rpc;

        @(negedge clk);

        // zero-wait memory, decode always ready
        lat_mode = 0;
        do_reset();
        cycle(1, 0, 0); chk("p1 idle req", 32'(s_req), 32'd0);
        cycle(1, 0, 0); chk("p1 addr0", s_addr, 32'h0);
        cycle(1, 0, 0); chk("p1 addr4", s_addr, 32'h4);
        chk("p1 pc0", s_pc, 32'h0);
        chk("p1 ins0", s_ins, 32'h9E37_79B9);
        cycle(1, 0, 0); chk("p1 addr8", s_addr, 32'h8);
        chk("p1 pc4", s_pc, 32'h4);
        cycle(1, 0, 0); chk("p1 pc8", s_pc, 32'h8);

        // stalled decode, 2-cycle memory: fill to DEPTH and stop
        lat_mode = 1;
        do_reset();
        repeat (10) cycle(0, 0, 0);
        chk("p2 req dropped", 32'(s_req), 32'd0);
        cycle(0, 0, 0);
        chk("p2 req still low", 32'(s_req), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cycle(1, 0, 0);
            chk("p2 drain pc", s_pc, 32'(k * 4));
        end

        // redirect while a request is outstanding
        lat_mode = 2;
        do_reset();
        found = 0;
        for (int i = 0; i < 60; i++) begin
            cycle(1, 0, 0);
            if (s_req && s_addr == 32'h14) begin found = 1; break; end
        end
        chk("p3 reach 0x14", 32'(found), 32'd1);
        cycle(1, 1, 32'h100);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0, 0);
            if (s_req && s_addr != 32'h14) begin found = 1; break; end
        end
        chk("p3 next req 0x100", s_addr, 32'h100);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0, 0);
            if (s_valid) begin found = 1; break; end
        end
        chk("p3 first pc 0x100", s_pc, 32'h100);

        // redirect coinciding with ack and pop
        lat_mode = 0;
        do_reset();
        repeat (4) cycle(1, 0, 0);
        cycle(1, 1, 32'h203);
        chk("p4 valid at redirect", 32'(s_valid), 32'd1);
        chk("p4 req at redirect", 32'(s_req), 32'd1);
        cycle(1, 0, 0);
        chk("p4 flushed", 32'(s_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (s_req) break;
            cycle(1, 0, 0);
        end
        chk("p4 fetch 0x200", s_addr, 32'h200);

        // PC wrap
        cycle(1, 1, 32'hFFFF_FFFC);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 0);
            if (s_req && s_addr == 32'hFFFF_FFFC) begin found = 1; break; end
        end
        chk("p5 reach top", 32'(found), 32'd1);
        cycle(1, 0, 0);
        chk("p5 wrap addr", s_addr, 32'h0);

        // reset mid-stream with three words buffered
        lat_mode = 0;
        do_reset();
        repeat (4) cycle(0, 0, 0);
        chk("p6 buffered", 32'(s_valid), 32'd1);
        do_reset();
        cycle(1, 0, 0); chk("p6 idle after rst", 32'(s_req), 32'd0);
        cycle(1, 0, 0); chk("p6 restart addr", s_addr, RPC);

        // random traffic
        lat_mode = -1;
        for (int i = 0; i < 4000; i++) begin
            rdy = ($urandom_range(0, 9) < 7) && ((i / 200) % 3 != 2);
            rd = ($urandom_range(0, 29) == 0);
            rpc = ($urandom_range(0, 3) == 0) ?
                  (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cycle(rdy, rd, rpc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
